// File: rtl/mips_alu_exec_unit.sv
// MIPS execute stage: ALU-control decode plus a WIDTH-bit ALU, one output register stage.
// 1-cycle latency, accepts every cycle, no backpressure; `ALU_XOR_EN adds funct 100110 (xor).
module mips_alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             carry_out,
  output logic [3:0]       alu_ctrl,
  output logic             illegal
);

  localparam int MSB = WIDTH - 1;

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_XOR = 4'b0011;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b0111;
  localparam logic [3:0] CTRL_NOR = 4'b1100;
  localparam logic [3:0] CTRL_ILL = 4'b1111;

  logic [3:0]       ctrl_d;
  logic             illegal_d;
  logic [WIDTH-1:0] result_d;
  logic             zero_d;
  logic             overflow_d;
  logic             carry_d;

  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   diff_w;
  logic             ovf_add;
  logic             ovf_sub;

  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             overflow_q;
  logic             carry_q;
  logic [3:0]       ctrl_q;
  logic             illegal_q;

  always_comb begin
    ctrl_d    = CTRL_ILL;
    illegal_d = 1'b1;
    unique case (alu_op)
      2'b00: begin
        ctrl_d    = CTRL_ADD;
        illegal_d = 1'b0;
      end
      2'b01: begin
        ctrl_d    = CTRL_SUB;
        illegal_d = 1'b0;
      end
      2'b10: begin
        illegal_d = 1'b0;
        case (funct)
          6'b100000: ctrl_d = CTRL_ADD;
          6'b100010: ctrl_d = CTRL_SUB;
          6'b100100: ctrl_d = CTRL_AND;
          6'b100101: ctrl_d = CTRL_OR;
          6'b100111: ctrl_d = CTRL_NOR;
          6'b101010: ctrl_d = CTRL_SLT;
`ifdef ALU_XOR_EN
          6'b100110: ctrl_d = CTRL_XOR;
`endif
          default: begin
            ctrl_d    = CTRL_ILL;
            illegal_d = 1'b1;
          end
        endcase
      end
      default: begin
        ctrl_d    = CTRL_ILL;
        illegal_d = 1'b1;
      end
    endcase
  end

  // One shared adder pair; subtraction is a + ~b + 1 so its carry means a >= b unsigned.
  assign sum_w   = {1'b0, a} + {1'b0, b};
  assign diff_w  = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
  assign ovf_add = (a[MSB] == b[MSB]) && (sum_w[MSB] != a[MSB]);
  assign ovf_sub = (a[MSB] != b[MSB]) && (diff_w[MSB] != a[MSB]);

  always_comb begin
    result_d   = '0;
    overflow_d = 1'b0;
    carry_d    = 1'b0;
    case (ctrl_d)
      CTRL_ADD: begin
        result_d   = sum_w[MSB:0];
        carry_d    = sum_w[WIDTH];
        overflow_d = ovf_add;
      end
      CTRL_SUB: begin
        result_d   = diff_w[MSB:0];
        carry_d    = diff_w[WIDTH];
        overflow_d = ovf_sub;
      end
      CTRL_AND: result_d = a & b;
      CTRL_OR:  result_d = a | b;
      CTRL_NOR: result_d = ~(a | b);
      CTRL_XOR: result_d = a ^ b;
      CTRL_SLT: begin
        // Sign of the difference corrected by overflow gives the true signed compare.
        result_d[0] = diff_w[MSB] ^ ovf_sub;
        carry_d     = diff_w[WIDTH];
      end
      default: result_d = '0;
    endcase
  end

  assign zero_d = (result_d == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      overflow_q  <= 1'b0;
      carry_q     <= 1'b0;
      ctrl_q      <= 4'b0000;
      illegal_q   <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        result_q   <= result_d;
        zero_q     <= zero_d;
        overflow_q <= overflow_d;
        carry_q    <= carry_d;
        ctrl_q     <= ctrl_d;
        illegal_q  <= illegal_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign overflow  = overflow_q;
  assign carry_out = carry_q;
  assign alu_ctrl  = ctrl_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_mips_alu_exec_unit.sv
// Bench for mips_alu_exec_unit: arithmetic reference model, per-cycle compare, literal pins.
module tb_mips_alu_exec_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic [31:0] result;
  logic        zero;
  logic        overflow;
  logic        carry_out;
  logic [3:0]  alu_ctrl;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  mips_alu_exec_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .alu_op(alu_op), .funct(funct),
    .a(a), .b(b), .out_valid(out_valid), .result(result), .zero(zero),
    .overflow(overflow), .carry_out(carry_out), .alu_ctrl(alu_ctrl), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: straight from the instruction semantics using wide signed/unsigned arithmetic.
  function automatic void model(input logic [1:0] op, input logic [5:0] f,
                                input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output logic ov, output logic cy,
                                output logic [3:0] ctrl, output logic ill);
    longint sx, sy, s;
    longint unsigned ux, uy, us;
    sx = longint'($signed(x)); sy = longint'($signed(y));
    ux = longint'({32'd0, x});  uy = longint'({32'd0, y});
    ctrl = 4'hF; ill = 1'b1;
    if (op == 2'b00) begin ctrl = 4'b0010; ill = 1'b0; end
    else if (op == 2'b01) begin ctrl = 4'b0110; ill = 1'b0; end
    else if (op == 2'b10) begin
      ill = 1'b0;
      case (f)
        6'b100000: ctrl = 4'b0010;
        6'b100010: ctrl = 4'b0110;
        6'b100100: ctrl = 4'b0000;
        6'b100101: ctrl = 4'b0001;
        6'b100111: ctrl = 4'b1100;
        6'b101010: ctrl = 4'b0111;
`ifdef ALU_XOR_EN
        6'b100110: ctrl = 4'b0011;
`endif
        default: begin ctrl = 4'hF; ill = 1'b1; end
      endcase
    end
    r = 32'd0; ov = 1'b0; cy = 1'b0;
    case (ctrl)
      4'b0010: begin
        us = ux + uy; r = us[31:0]; cy = (us >= 64'h1_0000_0000);
        s = sx + sy; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0110: begin
        r = x - y; cy = (ux >= uy);
        s = sx - sy; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0000: r = x & y;
      4'b0001: r = x | y;
      4'b1100: r = ~(x | y);
      4'b0011: r = x ^ y;
      4'b0111: begin r = (sx < sy) ? 32'd1 : 32'd0; cy = (ux >= uy); end
      default: r = 32'd0;
    endcase
  endfunction

  logic        e_vld, e_z, e_ov, e_cy, e_ill;
  logic [31:0] e_res;
  logic [3:0]  e_ctrl;

  always @(posedge clk or negedge rst_n) begin
    logic [31:0] r; logic ov, cy, ill; logic [3:0] c;
    if (!rst_n) begin
      e_vld <= 0; e_res <= 0; e_z <= 0; e_ov <= 0; e_cy <= 0; e_ctrl <= 0; e_ill <= 0;
    end else begin
      e_vld <= in_valid;
      if (in_valid) begin
        model(alu_op, funct, a, b, r, ov, cy, c, ill);
        e_res <= r; e_z <= (r == 32'd0); e_ov <= ov; e_cy <= cy; e_ctrl <= c; e_ill <= ill;
      end
    end
  end

  always @(negedge clk) begin
    chk("m_out_valid", {31'd0, out_valid}, {31'd0, e_vld});
    chk("m_result", result, e_res);
    chk("m_zero", {31'd0, zero}, {31'd0, e_z});
    chk("m_overflow", {31'd0, overflow}, {31'd0, e_ov});
    chk("m_carry_out", {31'd0, carry_out}, {31'd0, e_cy});
    chk("m_alu_ctrl", {28'd0, alu_ctrl}, {28'd0, e_ctrl});
    chk("m_illegal", {31'd0, illegal}, {31'd0, e_ill});
  end

  // Drives one valid operation, then pins the registered outputs to hand-computed values.
  task automatic directed(input string nm, input logic [1:0] op, input logic [5:0] f,
                          input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] xr, input logic xz, input logic xov,
                          input logic xcy, input logic [3:0] xc, input logic xill);
    @(posedge clk); #2;
    in_valid = 1'b1; alu_op = op; funct = f; a = x; b = y;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({nm, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({nm, "_result"}, result, xr);
    chk({nm, "_zero"}, {31'd0, zero}, {31'd0, xz});
    chk({nm, "_ovf"}, {31'd0, overflow}, {31'd0, xov});
    chk({nm, "_carry"}, {31'd0, carry_out}, {31'd0, xcy});
    chk({nm, "_ctrl"}, {28'd0, alu_ctrl}, {28'd0, xc});
    chk({nm, "_illegal"}, {31'd0, illegal}, {31'd0, xill});
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0: v = 32'h7FFF_FFFF;
      1: v = 32'h8000_0000;
      2: v = 32'hFFFF_FFFF;
      3: v = 32'h0000_0000;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  function automatic logic [5:0] pick_funct();
    logic [5:0] tbl [8];
    tbl = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
            6'b100111, 6'b101010, 6'b100110, 6'b000000};
    if ($urandom_range(0, 9) == 0) return 6'($urandom);
    return tbl[$urandom_range(0, 7)];
  endfunction

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; alu_op = 2'b00; funct = 6'd0; a = 32'd0; b = 32'd0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_ctrl", {28'd0, alu_ctrl}, 32'd0);

    directed("load",   2'b00, 6'b100010, 32'd5,         32'hFFFF_FFFC, 32'd1,         0, 0, 1, 4'b0010, 0);
    directed("addovf", 2'b00, 6'b000000, 32'h7FFF_FFFF, 32'd1,         32'h8000_0000, 0, 1, 0, 4'b0010, 0);
    directed("subovf", 2'b01, 6'b000000, 32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 0, 1, 1, 4'b0110, 0);
    directed("beq",    2'b01, 6'b101010, 32'h1234,      32'h1234,      32'd0,         1, 0, 1, 4'b0110, 0);
    directed("and",    2'b10, 6'b100100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 0, 0, 0, 4'b0000, 0);
    directed("or",     2'b10, 6'b100101, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 0, 0, 0, 4'b0001, 0);
    directed("nor",    2'b10, 6'b100111, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h000F_000F, 0, 0, 0, 4'b1100, 0);
    directed("slt",    2'b10, 6'b101010, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd1,         0, 0, 1, 4'b0111, 0);
    directed("sltovf", 2'b10, 6'b101010, 32'h7FFF_FFFF, 32'h8000_0000, 32'd0,         1, 0, 0, 4'b0111, 0);
    directed("radd",   2'b10, 6'b100000, 32'hFFFF_FFFF, 32'd1,         32'd0,         1, 0, 1, 4'b0010, 0);
`ifdef ALU_XOR_EN
    directed("xor",    2'b10, 6'b100110, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 0, 0, 0, 4'b0011, 0);
`else
    directed("xorill", 2'b10, 6'b100110, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0,         1, 0, 0, 4'b1111, 1);
`endif
    directed("op11",   2'b11, 6'b100000, 32'h1111_1111, 32'h2222_2222, 32'd0,         1, 0, 0, 4'b1111, 1);
    directed("badfn",  2'b10, 6'b000000, 32'h1111_1111, 32'h2222_2222, 32'd0,         1, 0, 0, 4'b1111, 1);

    // Idle cycles: valid drops, everything else holds the illegal capture.
    a = 32'hDEAD_BEEF; b = 32'h1; alu_op = 2'b00;
    repeat (2) begin
      @(posedge clk); #1;
      chk("hold_valid", {31'd0, out_valid}, 32'd0);
      chk("hold_ctrl", {28'd0, alu_ctrl}, 32'hF);
      chk("hold_illegal", {31'd0, illegal}, 32'd1);
      chk("hold_zero", {31'd0, zero}, 32'd1);
      chk("hold_result", result, 32'd0);
    end

    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #2;
      in_valid = ($urandom_range(0, 3) != 0);
      alu_op = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b10;
      funct = pick_funct();
      a = pick_operand();
      b = ($urandom_range(0, 7) == 0) ? a : pick_operand();
    end

    // Asynchronous reset mid-cycle with nonzero outputs.
    @(posedge clk); #2;
    in_valid = 1'b1; alu_op = 2'b00; a = 32'd1; b = 32'd1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pre_reset_result", result, 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", {31'd0, out_valid}, 32'd0);
    chk("async_result", result, 32'd0);
    chk("async_ctrl", {28'd0, alu_ctrl}, 32'd0);
    chk("async_flags", {28'd0, zero, overflow, carry_out, illegal}, 32'd0);
    @(posedge clk); #3 rst_n = 1'b1;

    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #2;
      in_valid = $urandom_range(0, 1) == 1;
      alu_op = 2'($urandom);
      funct = pick_funct();
      a = pick_operand();
      b = pick_operand();
    end
    @(posedge clk); #2 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
